// File: rtl/ascii_int_reader_if.sv
// ascii_int_reader_if
//   Bundles the byte-stream, result and echo signals of ascii_int_reader.
//   The parser itself connects through the slave modport; whatever feeds it
//   (UART receiver/transmitter glue, or a bench) uses the master modport.
//
//   Signals:
//     rx_data      [7:0]       received byte, valid when new_rx_data=1
//     new_rx_data              one-cycle receive strobe
//     value        [WIDTH-1:0] last successfully parsed integer
//     new_value                one-cycle strobe, value updated same cycle
//     err                      one-cycle strobe for a rejected token
//     tx_data      [7:0]       echo byte (the buffered byte)
//     new_tx_data              echo request to the transmitter
//     tx_busy                  transmitter busy
//     echo_drop                one-cycle strobe, a byte was not echoed
interface ascii_int_reader_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       rx_data;
    logic             new_rx_data;
    logic [WIDTH-1:0] value;
    logic             new_value;
    logic             err;
    logic [7:0]       tx_data;
    logic             new_tx_data;
    logic             tx_busy;
    logic             echo_drop;

    // Environment side: drives the receive stream and transmitter status.
    modport master (
        output rx_data,
        output new_rx_data,
        output tx_busy,
        input  value,
        input  new_value,
        input  err,
        input  tx_data,
        input  new_tx_data,
        input  echo_drop
    );

    // Parser side.
    modport slave (
        input  rx_data,
        input  new_rx_data,
        input  tx_busy,
        output value,
        output new_value,
        output err,
        output tx_data,
        output new_tx_data,
        output echo_drop
    );
endinterface

// File: rtl/ascii_int_reader.sv
// ascii_int_reader
//   Receive-side decimal parser for the UART command path. Converts ASCII
//   decimal tokens (optional leading '-') into WIDTH-bit two's complement
//   integers, strobes each result, flags malformed or out-of-range tokens,
//   and echoes every received byte through a one-entry buffer.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   ascii_int_reader_if.slave: rx_data/new_rx_data in,
//           value/new_value/err out, tx_data/new_tx_data/echo_drop out,
//           tx_busy in
//
//   Parameters:
//     WIDTH       result width in bits (must match the interface WIDTH)
//     MAX_DIGITS  maximum digit characters per token, leading zeros included
module ascii_int_reader #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    ascii_int_reader_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int EXT_W = WIDTH + 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SIGN   = 2'd1;
    localparam logic [1:0] ST_DIGITS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    // ------------------------------------------------------------------
    // Parser state
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic             neg;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] value_q;
    logic             new_value_q;
    logic             err_q;

    // ------------------------------------------------------------------
    // Echo buffer state
    // ------------------------------------------------------------------
    logic [7:0]       echo_byte;
    logic             echo_full;
    logic             echo_drop_q;
    logic             echo_drain;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic       is_digit;
    logic       is_minus;
    logic       is_term;
    logic [3:0] digit;

    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_minus = (bus.rx_data == 8'h2D);
    assign is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A) ||
                      (bus.rx_data == 8'h20);
    assign digit    = bus.rx_data[3:0];

    // ------------------------------------------------------------------
    // Accumulator arithmetic
    // acc*10 + digit is formed 4 bits wider than the result so that the
    // overflow comparison against the signed limit is exact: acc itself
    // never exceeds 2^(WIDTH-1), so acc*10+9 always fits in WIDTH+4 bits.
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] acc_x10;
    logic [EXT_W-1:0] acc_next;
    logic [EXT_W-1:0] limit;
    logic             overflow;
    logic             cnt_full;
    logic [WIDTH-1:0] digit_w;
    logic [WIDTH-1:0] result;

    assign acc_ext  = {4'b0000, acc};
    assign acc_x10  = (acc_ext << 3) + (acc_ext << 1);
    assign acc_next = acc_x10 + {{(EXT_W-4){1'b0}}, digit};

    // Negative tokens may reach one further: 2^(WIDTH-1) negates to the
    // most negative representable value.
    assign limit    = neg ? (EXT_W'(1) << (WIDTH - 1))
                          : (EXT_W'(1) << (WIDTH - 1)) - EXT_W'(1);
    assign overflow = (acc_next > limit);
    assign cnt_full = (cnt == CNT_W'(MAX_DIGITS));

    assign digit_w  = {{(WIDTH-4){1'b0}}, digit};
    assign result   = neg ? (~acc + {{(WIDTH-1){1'b0}}, 1'b1}) : acc;

    // ------------------------------------------------------------------
    // Parser FSM: advances only on received bytes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            neg         <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            value_q     <= '0;
            new_value_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            new_value_q <= 1'b0;
            err_q       <= 1'b0;

            if (bus.new_rx_data) begin
                case (state)
                    ST_IDLE: begin
                        // Leading terminators are skipped silently.
                        if (is_minus) begin
                            neg   <= 1'b1;
                            state <= ST_SIGN;
                        end else if (is_digit) begin
                            acc   <= digit_w;
                            cnt   <= CNT_W'(1);
                            state <= ST_DIGITS;
                        end else if (!is_term) begin
                            state <= ST_ERROR;
                        end
                    end

                    ST_SIGN: begin
                        if (is_digit) begin
                            acc   <= digit_w;
                            cnt   <= CNT_W'(1);
                            state <= ST_DIGITS;
                        end else if (is_term) begin
                            // A lone '-' is a rejected token.
                            err_q <= 1'b1;
                            neg   <= 1'b0;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end

                    ST_DIGITS: begin
                        if (is_digit) begin
                            if (cnt_full || overflow) begin
                                state <= ST_ERROR;
                            end else begin
                                acc <= acc_next[WIDTH-1:0];
                                cnt <= cnt + 1'b1;
                            end
                        end else if (is_term) begin
                            value_q     <= result;
                            new_value_q <= 1'b1;
                            neg         <= 1'b0;
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end

                    ST_ERROR: begin
                        // Discard everything up to the next terminator.
                        if (is_term) begin
                            err_q <= 1'b1;
                            neg   <= 1'b0;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        neg   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Echo buffer
    // A byte arriving while the buffer drains replaces it and keeps the
    // buffer full; the transmitter is expected to raise tx_busy next cycle,
    // which holds off the request for the newly loaded byte.
    // ------------------------------------------------------------------
    assign echo_drain = echo_full && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_byte   <= '0;
            echo_full   <= 1'b0;
            echo_drop_q <= 1'b0;
        end else begin
            echo_drop_q <= 1'b0;
            if (bus.new_rx_data) begin
                if (!echo_full || echo_drain) begin
                    echo_byte <= bus.rx_data;
                    echo_full <= 1'b1;
                end else begin
                    echo_drop_q <= 1'b1;
                end
            end else if (echo_drain) begin
                echo_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.value       = value_q;
    assign bus.new_value   = new_value_q;
    assign bus.err         = err_q;
    assign bus.tx_data     = echo_byte;
    assign bus.new_tx_data = echo_drain;
    assign bus.echo_drop   = echo_drop_q;

endmodule

// File: tb/tb_ascii_int_reader.sv
// tb_ascii_int_reader
//   Drives ascii_int_reader with directed strings and random tokens. The
//   reference model works on whole tokens: bytes between terminators are
//   collected and evaluated with integer arithmetic when a terminator arrives.
module tb_ascii_int_reader;

    localparam int WIDTH = 32;
    localparam int MAXD  = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ascii_int_reader_if #(.WIDTH(WIDTH)) bus ();

    ascii_int_reader #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model state
    byte unsigned tok[$];
    logic [31:0]  m_value = '0;
    bit           m_nv    = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_drop  = 1'b0;
    bit           m_full  = 1'b0;
    logic [7:0]   m_tx    = '0;
    bit           armed   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate one complete token. kind=1 valid number, kind=0 rejected.
    function automatic void eval_token(input byte unsigned t[$], output int kind,
                                       output logic [31:0] v);
        int     first;
        bit     ng;
        longint mag;
        int     nd;
        kind  = 0;
        v     = '0;
        first = 0;
        ng    = 1'b0;
        mag   = 0;
        nd    = 0;
        if (t.size() > 0 && t[0] == 8'h2D) begin
            ng    = 1'b1;
            first = 1;
        end
        for (int k = first; k < t.size(); k++) begin
            if (t[k] < 8'h30 || t[k] > 8'h39) return;
            nd++;
            if (nd > MAXD) return;
            mag = mag * 10 + longint'(t[k] - 8'h30);
        end
        if (nd == 0) return;
        if (mag > (ng ? 64'sd2147483648 : 64'sd2147483647)) return;
        kind = 1;
        v    = ng ? 32'(-mag) : 32'(mag);
    endfunction

    function automatic bit is_term(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
    endfunction

    // One clock cycle: drive inputs, check the combinational echo request,
    // advance the model on the edge, then check registered outputs.
    task automatic step(input bit v, input logic [7:0] b, input bit busy, input bit r);
        bit          drain;
        int          kind;
        logic [31:0] val;
        @(negedge clk);
        rst             = r;
        bus.new_rx_data = v;
        bus.rx_data     = b;
        bus.tx_busy     = busy;
        #1;
        if (armed) check("new_tx_data", bus.new_tx_data, m_full && !busy);
        @(posedge clk);
        if (r) begin
            tok.delete();
            m_value = '0;
            m_nv    = 1'b0;
            m_err   = 1'b0;
            m_drop  = 1'b0;
            m_full  = 1'b0;
            m_tx    = '0;
        end else begin
            drain  = m_full && !busy;
            m_nv   = 1'b0;
            m_err  = 1'b0;
            m_drop = 1'b0;
            if (v) begin
                if (!m_full || drain) begin
                    m_full = 1'b1;
                    m_tx   = b;
                end else begin
                    m_drop = 1'b1;
                end
                if (is_term(b)) begin
                    if (tok.size() > 0) begin
                        eval_token(tok, kind, val);
                        if (kind == 1) begin
                            m_value = val;
                            m_nv    = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                        tok.delete();
                    end
                end else begin
                    tok.push_back(b);
                end
            end else if (drain) begin
                m_full = 1'b0;
            end
        end
        #1;
        armed = 1'b1;
        check("value",     bus.value,     m_value);
        check("new_value", bus.new_value, m_nv);
        check("err",       bus.err,       m_err);
        check("echo_drop", bus.echo_drop, m_drop);
        check("tx_data",   bus.tx_data,   m_tx);
    endtask

    function automatic bit pick_busy(input int mode);
        if (mode == 2) return ($urandom_range(0, 3) == 0);
        return (mode == 1);
    endfunction

    // Send a string; gap idle cycles follow each byte.
    // busy_mode: 0 tx_busy low, 1 high, 2 random.
    task automatic send_str(input string s, input int gap, input int busy_mode);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            step(1'b1, c, pick_busy(busy_mode), 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, pick_busy(busy_mode), 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, busy, 1'b0);
    endtask

    string bnd[6]   = '{"2147483647", "-2147483648", "2147483648",
                        "-2147483649", "0", "-0"};
    string pool     = "09-x3 5";
    string terms    = "\015\012 ";

    initial begin
        string s;
        int    j;
        rst             = 1'b1;
        bus.new_rx_data = 1'b0;
        bus.rx_data     = '0;
        bus.tx_busy     = 1'b0;

        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Directed sequences
        send_str("1234\015", 3, 0);
        idle(3, 1'b0);
        send_str("-2147483648 ", 0, 0);
        send_str("2147483648\012", 0, 0);
        send_str("\015\01212a4\015", 1, 0);
        send_str("7\015", 0, 0);
        send_str("-\015", 0, 0);
        send_str("00000000001\015", 0, 0);
        send_str("0000000001\015", 0, 0);
        send_str("2147483647 -2147483649 ", 0, 0);
        idle(2, 1'b0);

        // Echo overflow: 'A' buffered, 'B' and 'C' dropped
        send_str("ABC", 0, 1);
        idle(2, 1'b1);
        idle(3, 1'b0);

        // Reset mid-token
        send_str("55", 0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        send_str("3\015", 0, 0);
        idle(2, 1'b0);

        // Random tokens
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: s = $sformatf("%0d", $signed($urandom()));
                1: s = bnd[$urandom_range(0, 5)];
                2: begin
                    s = "";
                    repeat ($urandom_range(0, 10)) s = {s, "0"};
                    s = {s, "7"};
                end
                default: begin
                    s = "";
                    repeat ($urandom_range(1, 6)) begin
                        j = $urandom_range(0, pool.len() - 1);
                        s = {s, pool.substr(j, j)};
                    end
                end
            endcase
            j = $urandom_range(0, 2);
            s = {s, terms.substr(j, j)};
            send_str(s, $urandom_range(0, 2), 2);
        end
        idle(4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
